// File: rtl/decode_pkg.sv
// Shared widths, named opcodes and helpers for the UAZ instruction decode stage.
package decode_pkg;

    localparam int OP_W_DEF  = 3;
    localparam int REG_W_DEF = 3;

    localparam logic [2:0] OPC_NOP = 3'd0;
    localparam logic [2:0] OPC_MOV = 3'd1;
    localparam logic [2:0] OPC_ADD = 3'd2;
    localparam logic [2:0] OPC_SUB = 3'd3;
    localparam logic [2:0] OPC_AND = 3'd4;
    localparam logic [2:0] OPC_OR  = 3'd5;
    localparam logic [2:0] OPC_LD  = 3'd6;
    localparam logic [2:0] OPC_ST  = 3'd7;

    function automatic int instr_w(input int op_w, input int reg_w);
        return op_w + 2 * reg_w;
    endfunction

    // One bit of a one-hot vector: set when the opcode value selects position k.
    function automatic logic onehot_bit(input int op, input int k);
        return op == k;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready register with a one-entry skid (two entries total) and flush.
module pipe_skid_reg #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              out_free;
    logic              accept;

    // in_ready depends only on state (and reset), never on out_ready.
    assign in_ready  = !skid_valid_q && !rst;
    assign accept    = in_valid && in_ready;
    assign out_free  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered UAZ decode stage: skid-buffered handshake, field split, one-hot opcode, emit counter.
// Define DECODE_HAZARD_EN to add out_hazard (RX/RY match against last emitted RX).
module instr_decode_stage import decode_pkg::*; #(
    parameter  int OP_W    = OP_W_DEF,
    parameter  int REG_W   = REG_W_DEF,
    parameter  int CNT_W   = 16,
    localparam int INSTR_W = instr_w(OP_W, REG_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      out_op,
    output logic [REG_W-1:0]     out_rx,
    output logic [REG_W-1:0]     out_ry,
    output logic [2**OP_W-1:0]   out_op_onehot,
    output logic [CNT_W-1:0]     out_count
`ifdef DECODE_HAZARD_EN
   ,output logic                 out_hazard
`endif
);

    localparam int NOH = 2**OP_W;

    logic [INSTR_W-1:0] word;
    logic               emit;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    pipe_skid_reg #(.DATA_W(INSTR_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (word)
    );

    assign emit   = out_valid && out_ready;
    assign out_op = word[INSTR_W-1 -: OP_W];
    assign out_rx = word[2*REG_W-1 -: REG_W];
    assign out_ry = word[REG_W-1:0];

    always_comb begin
        out_op_onehot = '0;
        for (int k = 0; k < NOH; k++) begin
            out_op_onehot[k] = out_valid && onehot_bit(int'(out_op), k);
        end
    end

    // Counter survives flush; an emit in a flush cycle still counts.
    always_comb begin
        out_count_d = out_count_q;
        if (emit) out_count_d = out_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) out_count_q <= '0;
        else     out_count_q <= out_count_d;
    end

    assign out_count = out_count_q;

`ifdef DECODE_HAZARD_EN
    logic [REG_W-1:0] last_rx_q, last_rx_d;
    logic             last_vld_q, last_vld_d;

    always_comb begin
        last_rx_d  = last_rx_q;
        last_vld_d = last_vld_q;
        if (flush) begin
            last_rx_d  = '0;
            last_vld_d = 1'b0;
        end else if (emit) begin
            last_rx_d  = out_rx;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_rx_q  <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_rx_q  <= last_rx_d;
            last_vld_q <= last_vld_d;
        end
    end

    // Tracker and output word change on the same edge, so this equals a value registered at load.
    assign out_hazard = out_valid && last_vld_q &&
                        ((out_rx == last_rx_q) || (out_ry == last_rx_q));
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage (counter built 4 bits wide to exercise wrap).
module tb_instr_decode_stage;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [8:0] in_instr;
    logic [2:0] out_op, out_rx, out_ry;
    logic [7:0] out_op_onehot;
    logic [3:0] out_count;
`ifdef DECODE_HAZARD_EN
    logic       out_hazard;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] w;

    always #5 clk = ~clk;

    instr_decode_stage #(.OP_W(3), .REG_W(3), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_instr      (in_instr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_op        (out_op),
        .out_rx        (out_rx),
        .out_ry        (out_ry),
        .out_op_onehot (out_op_onehot),
        .out_count     (out_count)
`ifdef DECODE_HAZARD_EN
       ,.out_hazard    (out_hazard)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] instr);
        in_instr = instr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_count", 32'(out_count), 0);
        check("rst_onehot", 32'(out_op_onehot), 0);
        check("rst_op", 32'(out_op), 0);
        rst = 1'b0; #1;
        check("rel_ready", 32'(in_ready), 1);

        // basic decode
        out_ready = 1'b1;
        push(9'b101_011_110);
        check("bas_valid", 32'(out_valid), 1);
        check("bas_op", 32'(out_op), 5);
        check("bas_rx", 32'(out_rx), 3);
        check("bas_ry", 32'(out_ry), 6);
        check("bas_onehot", 32'(out_op_onehot), 32'h20);
        check("bas_cnt0", 32'(out_count), 0);
        tick();
        check("bas_cnt1", 32'(out_count), 1);
        check("bas_empty", 32'(out_valid), 0);
        check("bas_oh0", 32'(out_op_onehot), 0);

        // backpressure: A held, B in skid, C waits
        out_ready = 1'b0;
        push(9'b001_010_011);
        check("bp_ready_a", 32'(in_ready), 1);
        push(9'b110_100_001);
        check("bp_ready_b", 32'(in_ready), 0);
        check("bp_hold_op", 32'(out_op), 1);
        in_instr = 9'b011_111_101; in_valid = 1'b1;
        tick();
        check("bp_hold_rx", 32'(out_rx), 2);
        check("bp_hold_ry", 32'(out_ry), 3);
        check("bp_ready_c", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        check("bp_b_op", 32'(out_op), 6);
        check("bp_b_rx", 32'(out_rx), 4);
        check("bp_cnt2", 32'(out_count), 2);
        tick();
        in_valid = 1'b0;
        check("bp_c_op", 32'(out_op), 3);
        check("bp_c_ry", 32'(out_ry), 5);
        check("bp_cnt3", 32'(out_count), 3);
        tick();
        check("bp_cnt4", 32'(out_count), 4);
        check("bp_empty", 32'(out_valid), 0);

        // flush with output and skid full, plus a same-cycle input
        out_ready = 1'b0;
        push(9'b111_000_111);
        push(9'b100_100_100);
        in_instr = 9'b010_010_010; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 0);
        check("fl_ready", 32'(in_ready), 1);
        check("fl_onehot", 32'(out_op_onehot), 0);
        check("fl_op", 32'(out_op), 0);
        check("fl_cnt", 32'(out_count), 4);
        out_ready = 1'b1;
        tick();
        check("fl_nodrop_in", 32'(out_valid), 0);
        check("fl_cnt_keep", 32'(out_count), 4);
        out_ready = 1'b0;
        push(9'b000_001_001);
        check("fl_g_valid", 32'(out_valid), 1);
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_emit_cnt", 32'(out_count), 5);
        check("fl_emit_vld", 32'(out_valid), 0);

        // reset mid-stream
        out_ready = 1'b0;
        push(9'b011_011_011);
        push(9'b101_101_101);
        rst = 1'b1;
        tick();
        check("mr_valid", 32'(out_valid), 0);
        check("mr_ready", 32'(in_ready), 0);
        check("mr_count", 32'(out_count), 0);
        check("mr_fields", 32'({out_op, out_rx, out_ry}), 0);
        check("mr_onehot", 32'(out_op_onehot), 0);
        rst = 1'b0; #1;
        check("mr_rel_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        tick();
        check("mr_no_stale", 32'(out_valid), 0);
        check("mr_cnt0", 32'(out_count), 0);

        // 17 emits on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            w = 9'(i * 37 + 5);
            in_instr = w; in_valid = 1'b1;
            tick();
            check("wr_valid", 32'(out_valid), 1);
            check("wr_word", 32'({out_op, out_rx, out_ry}), 32'(w));
            check("wr_cnt", 32'(out_count), 32'(i % 16));
        end
        in_valid = 1'b0;
        tick();
        check("wr_final", 32'(out_count), 1);
        check("wr_empty", 32'(out_valid), 0);

`ifdef DECODE_HAZARD_EN
        flush = 1'b1; tick(); flush = 1'b0;
        in_valid = 1'b1;
        in_instr = 9'b001_010_000; tick();
        check("hz_first", 32'(out_hazard), 0);
        in_instr = 9'b010_111_010; tick();
        check("hz_set", 32'(out_hazard), 1);
        in_instr = 9'b010_001_011; tick();
        check("hz_clear", 32'(out_hazard), 0);
        in_valid = 1'b0; tick();
        check("hz_empty", 32'(out_hazard), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
